// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge controller: enables a pair of rings, counts their edges over a gate window and compares.
// Optional macro RO_PUF_CNT_OUT_EN exposes the final counts on cnt_a_q/cnt_b_q.

module ro_puf_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ro,
  output logic o_rise
);
  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_ro;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
endmodule

module ro_puf_ctrl #(
  parameter int N_RO       = 8,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [$clog2(N_RO)-1:0] sel_a,
  input  logic [$clog2(N_RO)-1:0] sel_b,
  input  logic [N_RO-1:0]         ro_out,
  output logic [N_RO-1:0]         ro_en,
  output logic                    busy,
  output logic                    done,
  output logic                    resp,
  output logic                    tie,
  output logic                    err
`ifdef RO_PUF_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0]        cnt_a_q,
  output logic [CNT_W-1:0]        cnt_b_q
`endif
);
  localparam int SEL_W   = $clog2(N_RO);
  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [SEL_W-1:0] r_sel_a, r_sel_b;
  logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
  logic             r_done, r_resp, r_tie, r_err;
  logic [N_RO-1:0]  w_rise;
  logic             w_rng_ok, w_pair_ok, w_start_idle, w_inc_a, w_inc_b;

  genvar gi;
  generate
    for (gi = 0; gi < N_RO; gi++) begin : g_lane
      ro_puf_lane u_lane (.clk(clk), .rst_n(rst_n), .i_ro(ro_out[gi]), .o_rise(w_rise[gi]));
    end
    // Out-of-range indices only exist when N_RO is not a power of two.
    if ((1 << SEL_W) == N_RO) begin : g_rng_full
      assign w_rng_ok = 1'b1;
    end else begin : g_rng_chk
      assign w_rng_ok = (sel_a < SEL_W'(N_RO)) && (sel_b < SEL_W'(N_RO));
    end
  endgenerate

  assign w_pair_ok    = w_rng_ok && (sel_a != sel_b);
  assign w_start_idle = (r_state == S_IDLE) && start;
  assign w_inc_a      = (r_state == S_MEASURE) && w_rise[r_sel_a];
  assign w_inc_b      = (r_state == S_MEASURE) && w_rise[r_sel_b];

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      S_IDLE: if (start && w_pair_ok) begin
        w_state_nxt = S_SETTLE;
        w_tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
      end
      S_SETTLE: if (r_tmr == '0) begin
        w_state_nxt = S_MEASURE;
        w_tmr_nxt   = TMR_W'(WINDOW - 1);
      end else begin
        w_tmr_nxt = r_tmr - 1'b1;
      end
      S_MEASURE: if (r_tmr == '0) w_state_nxt = S_COMPARE;
                 else             w_tmr_nxt   = r_tmr - 1'b1;
      S_COMPARE: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_done  <= 1'b0;
      r_resp  <= 1'b0;
      r_tie   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == S_DONE) || (w_start_idle && !w_pair_ok);
      if (w_start_idle) begin
        r_sel_a <= sel_a;
        r_sel_b <= sel_b;
        r_cnt_a <= '0;
        r_cnt_b <= '0;
        r_err   <= !w_pair_ok;
      end else begin
        // Saturate rather than wrap so a very fast ring can never look slow.
        if (w_inc_a && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + 1'b1;
        if (w_inc_b && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + 1'b1;
      end
      if (r_state == S_COMPARE) begin
        r_resp <= (r_cnt_a > r_cnt_b);
        r_tie  <= (r_cnt_a == r_cnt_b);
        r_err  <= 1'b0;
      end
    end
  end

`ifdef RO_PUF_CNT_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (r_state == S_COMPARE) begin
      cnt_a_q <= r_cnt_a;
      cnt_b_q <= r_cnt_b;
    end
  end
`endif

  assign ro_en = ((r_state == S_SETTLE) || (r_state == S_MEASURE))
               ? ((N_RO'(1) << r_sel_a) | (N_RO'(1) << r_sel_b)) : '0;
  assign busy  = (r_state == S_SETTLE) || (r_state == S_MEASURE) || (r_state == S_COMPARE);
  assign done  = r_done;
  assign resp  = r_resp;
  assign tie   = r_tie;
  assign err   = r_err;
endmodule
